// File: rtl/seg_scan_dri_if.sv
//------------------------------------------------------------------------------
// Module : seg_scan_dri_if
// Brief  : Display register / pin bundle for the scanned 7-segment driver.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface seg_scan_dri_if #(
    parameter int NUM_DIG = 6
);
    logic [4*NUM_DIG-1:0] num;
    logic [NUM_DIG-1:0]   dp;
    logic                 hex_mode;
    logic                 en;
    logic [NUM_DIG-1:0]   seg_sel;
    logic [7:0]           seg_led;

    modport master (
        output num, dp, hex_mode, en,
        input  seg_sel, seg_led
    );

    modport slave (
        input  num, dp, hex_mode, en,
        output seg_sel, seg_led
    );
endinterface

`default_nettype wire

// File: rtl/seg_scan_dri.sv
//------------------------------------------------------------------------------
// Module : seg_scan_dri
// Brief  : Time-multiplexed NUM_DIG-digit 7-segment scanner with frame-coherent
//          capture, anti-ghost blanking, BCD/hex decode and decimal points.
//          Optional: LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg_scan_dri #(
    parameter int NUM_DIG     = 6,
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int SCAN_HZ     = 1_000,
    parameter int BLANK_CYC   = 16,
    parameter int SEG_ACT_LOW = 1,
    parameter int SEL_ACT_LOW = 1
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    seg_scan_dri_if.slave disp
);

    localparam int SCAN_DIV = CLK_FREQ_HZ / SCAN_HZ;
    localparam int CW       = $clog2(SCAN_DIV);
    localparam int IW       = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

    localparam logic [CW-1:0]      C_DIV_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]      C_BLANK     = CW'(BLANK_CYC);
    localparam logic [IW-1:0]      C_IDX_LAST  = IW'(NUM_DIG - 1);
    localparam logic [7:0]         C_LED_OFF   = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIG-1:0] C_SEL_OFF   = (SEL_ACT_LOW != 0) ? '1 : '0;

    function automatic logic [6:0] f_decode(input logic [3:0] nib, input logic hex);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        if (nib > 4'd9 && !hex) begin
            seg = 7'h40;
        end
        return seg;
    endfunction

    logic [CW-1:0]        div_cnt_q, div_cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 first_q;
    logic [4*NUM_DIG-1:0] num_q;
    logic [NUM_DIG-1:0]   dp_q;
    logic                 hex_q;
    logic [NUM_DIG-1:0]   seg_sel_q, seg_sel_d;
    logic [7:0]           seg_led_q, seg_led_d;

    logic                 w_slot_end;
    logic                 w_capture;
    logic                 w_lit;
    logic [3:0]           w_nib;
    logic                 w_dp;
    logic                 w_blank_dig;
    logic [NUM_DIG-1:0]   w_onehot;
    logic [NUM_DIG-1:0]   w_lzb;
    logic [NUM_DIG-1:0]   w_sel;
    logic [7:0]           w_led;

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; a digit is blank while every nibble at or above it is zero.
    always_comb begin : p_lzb
        logic v_zero;
        v_zero = 1'b1;
        w_lzb  = '0;
        for (int k = NUM_DIG - 1; k >= 0; k--) begin
            v_zero = v_zero & (num_q[4*k +: 4] == 4'd0);
            if (k != 0) begin
                w_lzb[k] = v_zero & ~dp_q[k];
            end
        end
    end
`else
    assign w_lzb = '0;
`endif

    always_comb begin
        w_slot_end = (div_cnt_q == C_DIV_LAST);
        div_cnt_d  = w_slot_end ? '0 : div_cnt_q + CW'(1);
        idx_d      = idx_q;
        if (w_slot_end) begin
            idx_d = (idx_q == C_IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        w_capture  = first_q | (w_slot_end & (idx_q == C_IDX_LAST));

        w_nib       = 4'd0;
        w_dp        = 1'b0;
        w_blank_dig = 1'b0;
        w_onehot    = '0;
        for (int k = 0; k < NUM_DIG; k++) begin
            if (idx_q == IW'(k)) begin
                w_nib       = num_q[4*k +: 4];
                w_dp        = dp_q[k];
                w_blank_dig = w_lzb[k];
                w_onehot[k] = 1'b1;
            end
        end

        w_lit = disp.en & (div_cnt_q >= C_BLANK);
        w_sel = w_lit ? w_onehot : '0;
        w_led = (w_lit && !w_blank_dig) ? {w_dp, f_decode(w_nib, hex_q)} : 8'h00;

        seg_sel_d = (SEL_ACT_LOW != 0) ? ~w_sel : w_sel;
        seg_led_d = (SEG_ACT_LOW != 0) ? ~w_led : w_led;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            idx_q     <= '0;
            first_q   <= 1'b1;
            num_q     <= '0;
            dp_q      <= '0;
            hex_q     <= 1'b0;
            seg_sel_q <= C_SEL_OFF;
            seg_led_q <= C_LED_OFF;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            first_q   <= 1'b0;
            if (w_capture) begin
                num_q <= disp.num;
                dp_q  <= disp.dp;
                hex_q <= disp.hex_mode;
            end
            seg_sel_q <= seg_sel_d;
            seg_led_q <= seg_led_d;
        end
    end

    assign disp.seg_sel = seg_sel_q;
    assign disp.seg_led = seg_led_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_dri.sv
//------------------------------------------------------------------------------
// Module : tb_seg_scan_dri
// Brief  : Scoreboard bench for seg_scan_dri (4 digits, 10-cycle slots, 2 blank).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seg_scan_dri;

    localparam int ND    = 4;
    localparam int DIV   = 10;
    localparam int BLANK = 2;
    localparam int FRAME = ND * DIV;

    typedef struct packed {
        logic [ND-1:0] sel;
        logic [7:0]    led;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    exp_t exp_q[$];

    logic [6:0] c_seg [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_scan_dri_if #(.NUM_DIG(ND)) disp ();

    seg_scan_dri #(
        .NUM_DIG    (ND),
        .CLK_FREQ_HZ(100),
        .SCAN_HZ    (10),
        .BLANK_CYC  (BLANK),
        .SEG_ACT_LOW(1),
        .SEL_ACT_LOW(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .disp (disp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: edge number since reset release gives slot, digit and frame directly.
    initial begin : p_model
        int          n;
        int          m;
        int          div;
        int          idx;
        int          hi;
        logic [15:0] snap_num;
        logic [ND-1:0] snap_dp;
        logic        snap_hex;
        logic [3:0]  nib;
        logic [7:0]  led_hi;
        exp_t        e;
        n        = 0;
        snap_num = '0;
        snap_dp  = '0;
        snap_hex = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                n        = 0;
                snap_num = '0;
                snap_dp  = '0;
                snap_hex = 1'b0;
                e.sel    = '1;
                e.led    = 8'hFF;
            end else begin
                n   = n + 1;
                m   = n - 1;
                div = m % DIV;
                idx = (m / DIV) % ND;
                if (disp.en && div >= BLANK) begin
                    nib    = snap_num[idx*4 +: 4];
                    led_hi = {snap_dp[idx], c_seg[nib]};
                    if (nib > 4'd9 && !snap_hex) led_hi[6:0] = 7'h40;
`ifdef LEADING_ZERO_BLANK_EN
                    hi = 0;
                    for (int k = 0; k < ND; k++) if (snap_num[k*4 +: 4] != 4'd0) hi = k;
                    if (idx > hi && !snap_dp[idx]) led_hi = 8'h00;
`else
                    hi = 0;
`endif
                    e.sel = ~(ND'(1) << idx);
                    e.led = ~led_hi;
                end else begin
                    e.sel = '1;
                    e.led = 8'hFF;
                end
                if (n == 1 || (n % FRAME) == 0) begin
                    snap_num = disp.num;
                    snap_dp  = disp.dp;
                    snap_hex = disp.hex_mode;
                end
            end
            exp_q.push_back(e);
        end
    end

    initial begin : p_monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (disp.seg_sel !== e.sel || disp.seg_led !== e.led) begin
                    n_fail++;
                    $display("FAIL scan t=%0t: sel=%h led=%h, expected sel=%h led=%h",
                             $time, disp.seg_sel, disp.seg_led, e.sel, e.led);
                end
            end
        end
    end

    task automatic run(input int cyc);
        repeat (cyc) @(negedge clk);
    endtask

    task automatic set_in(input logic [15:0] nv, input logic [ND-1:0] dv,
                          input logic hx, input logic ev);
        disp.num      = nv;
        disp.dp       = dv;
        disp.hex_mode = hx;
        disp.en       = ev;
    endtask

    initial begin : p_stim
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        set_in(16'h1234, '0, 1'b1, 1'b1);
        run(3);
        n_tests++;
        if (disp.seg_sel !== 4'hF || disp.seg_led !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset: sel=%h led=%h, expected sel=f led=ff",
                     disp.seg_sel, disp.seg_led);
        end
        rst_n = 1'b1;
        run(25);
        // Digit 2 of frame 0 is on screen; the new value must wait for frame 1.
        set_in(16'h5678, '0, 1'b1, 1'b1);
        run(70);
        set_in(16'h00AF, 4'b0001, 1'b1, 1'b1);
        run(80);
        set_in(16'h00AF, 4'b0001, 1'b0, 1'b1);
        run(80);
        set_in(16'h1234, '0, 1'b1, 1'b1);
        run(44);
        disp.en = 1'b0;
        run(7);
        disp.en = 1'b1;
        run(40);
        set_in(16'h0050, '0, 1'b0, 1'b1);
        run(90);
        set_in(16'h0000, '0, 1'b0, 1'b1);
        run(45);
        set_in(16'h0000, 4'b0100, 1'b1, 1'b1);
        run(45);
        for (int i = 0; i < 25; i++) begin
            set_in(16'($urandom), ND'($urandom), 1'($urandom), ($urandom_range(0, 9) != 0));
            run($urandom_range(1, 60));
        end
        set_in(16'h9A0C, 4'b1010, 1'b1, 1'b1);
        run(13);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (disp.seg_sel !== 4'hF || disp.seg_led !== 8'hFF) begin
            n_fail++;
            $display("FAIL async_reset: sel=%h led=%h, expected sel=f led=ff",
                     disp.seg_sel, disp.seg_led);
        end
        run(2);
        rst_n = 1'b1;
        run(90);
        n_tests++;
        if (exp_q.size() > 1) begin
            n_fail++;
            $display("FAIL queue_drain: pending=%0d, expected at most 1", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
